alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/control interface.
- Accepts a fetched MIPS instruction plus its register-file read data.
- Decodes it into ALU operands a/b, the 4-bit aluc code and writeback/memory control.
- Delivers the result through a registered valid/ready buffer with backpressure, sitting between register read and the execute stage.

Parameters:
- BUF_DEPTH, 2, output buffer entries. 1 = single pipeline register; 2 = skid buffer so in_ready is registered. Other values are illegal.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction and operands present
- in_ready  output  1  stage can accept this cycle
- instr  input  32  MIPS instruction word
- rs_data  input  32  register value for instr[25:21]
- rt_data  input  32  register value for instr[20:16]
- out_valid  output  1  issued entry present
- out_ready  input  1  execute stage consumes this cycle
- a  output  32  ALU operand a
- b  output  32  ALU operand b
- aluc  output  4  ALU operation code
- wreg  output  1  result written to register file
- wn  output  5  destination register
- m2reg  output  1  writeback from memory (lw)
- wmem  output  1  memory write (sw)
- br_eq  output  1  beq: branch taken when ALU z=1
- br_ne  output  1  bne: branch taken when ALU z=0
- illegal  output  1  unrecognised instruction (macro-dependent)

Behaviour:
- Reset: out_valid=0, all payload outputs 0, buffer emptied. in_ready=1 in the cycle after rst deasserts. Reset mid-operation discards all buffered entries.
- Transfer rules:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - Latency: an accepted instruction appears at the outputs the next cycle.
- Ordering: strict FIFO order. Payload is held stable while out_valid=1 and out_ready=0.
- BUF_DEPTH=2:
  - in_ready = (occupancy<2), registered.
  - A simultaneous push and pop at occupancy 2 is not possible, because in_ready=0.
  - At occupancy 1, simultaneous push and pop keeps occupancy at 1.
- BUF_DEPTH=1: in_ready = !out_valid | out_ready.
- aluc codes:
  - add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- R-type decode (op=000000, wreg=1, wn=rd):
  - funct 100000/100001 -> add; 100010/100011 -> sub; 100100 -> and; 100101 -> or; 100110 -> xor: a=rs_data, b=rt_data.
  - funct 000000/000010/000011 -> sll/srl/sra: a={27'b0,shamt}, b=rt_data.
- I-type decode (wn=rt, a=rs_data):
  - addi 001000 and addiu 001001 -> add, b=sign-extended imm.
  - andi 001100 -> and, ori 001101 -> or, xori 001110 -> xor; b=zero-extended imm.
  - lui 001111 -> lui, b={16'b0,imm}; the ALU performs the shift.
  - lw 100011 -> add, sign-extended imm, m2reg=1.
  - sw 101011 -> add, sign-extended imm, wreg=0, wmem=1.
  - beq 000100 / bne 000101 -> xor, a=rs_data, b=rt_data, wreg=0, br_eq/br_ne=1.
- wn=0 with wreg=1 is issued unchanged; the register file ignores $0.
- Every decoded control field not named above is 0.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: an unrecognised op/funct is issued as one entry with illegal=1, wreg=wmem=m2reg=br_eq=br_ne=0, aluc=0000, a=b=0.
- Undefined: an unrecognised instruction is accepted and silently dropped (no output entry), and illegal is tied 0.

Test Plan:
- add $3,$1,$2: instr=0x00221820, rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7, aluc=0000, wreg=1, wn=3.
- sll $2,$1,4: instr=0x00011100, rt_data=0x0000000F -> a=4, b=0x0000000F, aluc=0011, wn=2.
- Immediate extension:
  - addi 0x2001FFFF -> b=0xFFFFFFFF, aluc=0000, wn=1.
  - ori 0x3401FFFF -> b=0x0000FFFF, aluc=0101.
  - lui 0x3C011234 -> b=0x00001234, aluc=0110.
- Backpressure, BUF_DEPTH=2: out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts, payload stable. Release out_ready -> entries emerge in order, third accepted after first pop.
- beq 0x10220003 -> aluc=0010, br_eq=1, wreg=0. sw 0xAC22FFFC -> b=0xFFFFFFFC, wmem=1, wreg=0.
- Assert rst with 2 entries buffered -> next cycle out_valid=0, in_ready=1. Illegal op 0x3F -> illegal=1 with macro defined, no entry without it.

Source files
------------

// File: rtl/alu_issue_stage.sv
// MIPS ALU issue stage: decodes instr + register operands into ALU operands/control and
// delivers them through a valid/ready buffer (BUF_DEPTH 1 or 2). Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  aluc,
  output logic        wreg,
  output logic [4:0]  wn,
  output logic        m2reg,
  output logic        wmem,
  output logic        br_eq,
  output logic        br_ne,
  output logic        illegal
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        wreg;
    logic [4:0]  wn;
    logic        m2reg;
    logic        wmem;
    logic        br_eq;
    logic        br_ne;
    logic        illegal;
  } issue_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  generate
    if (BUF_DEPTH != 1 && BUF_DEPTH != 2) begin : g_bad_depth
      $error("alu_issue_stage: BUF_DEPTH must be 1 or 2");
    end
  endgenerate

  logic [5:0]  op, funct;
  logic [4:0]  rs_n, rt_n, rd_n, shamt;
  logic [31:0] sext, zext;

  assign op    = instr[31:26];
  assign rs_n  = instr[25:21];
  assign rt_n  = instr[20:16];
  assign rd_n  = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign sext  = {{16{instr[15]}}, instr[15:0]};
  assign zext  = {16'b0, instr[15:0]};

  issue_t dec;
  logic   dec_ok;

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    case (op)
      6'b000000: begin
        dec.wreg = 1'b1;
        dec.wn   = rd_n;
        dec.a    = rs_data;
        dec.b    = rt_data;
        case (funct)
          6'b100000, 6'b100001: dec.aluc = ALU_ADD;
          6'b100010, 6'b100011: dec.aluc = ALU_SUB;
          6'b100100:            dec.aluc = ALU_AND;
          6'b100101:            dec.aluc = ALU_OR;
          6'b100110:            dec.aluc = ALU_XOR;
          6'b000000: begin dec.aluc = ALU_SLL; dec.a = {27'b0, shamt}; end
          6'b000010: begin dec.aluc = ALU_SRL; dec.a = {27'b0, shamt}; end
          6'b000011: begin dec.aluc = ALU_SRA; dec.a = {27'b0, shamt}; end
          default:   dec_ok = 1'b0;
        endcase
      end
      6'b001000, 6'b001001: begin
        dec.aluc = ALU_ADD; dec.a = rs_data; dec.b = sext; dec.wreg = 1'b1; dec.wn = rt_n;
      end
      6'b001100: begin dec.aluc = ALU_AND; dec.a = rs_data; dec.b = zext; dec.wreg = 1'b1; dec.wn = rt_n; end
      6'b001101: begin dec.aluc = ALU_OR;  dec.a = rs_data; dec.b = zext; dec.wreg = 1'b1; dec.wn = rt_n; end
      6'b001110: begin dec.aluc = ALU_XOR; dec.a = rs_data; dec.b = zext; dec.wreg = 1'b1; dec.wn = rt_n; end
      // lui hands the raw immediate over; the ALU does the <<16
      6'b001111: begin dec.aluc = ALU_LUI; dec.a = rs_data; dec.b = zext; dec.wreg = 1'b1; dec.wn = rt_n; end
      6'b100011: begin
        dec.aluc = ALU_ADD; dec.a = rs_data; dec.b = sext; dec.wreg = 1'b1; dec.m2reg = 1'b1; dec.wn = rt_n;
      end
      6'b101011: begin dec.aluc = ALU_ADD; dec.a = rs_data; dec.b = sext; dec.wmem = 1'b1; dec.wn = rt_n; end
      6'b000100: begin dec.aluc = ALU_XOR; dec.a = rs_data; dec.b = rt_data; dec.br_eq = 1'b1; dec.wn = rt_n; end
      6'b000101: begin dec.aluc = ALU_XOR; dec.a = rs_data; dec.b = rt_data; dec.br_ne = 1'b1; dec.wn = rt_n; end
      default:   dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      dec = '0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      dec.illegal = 1'b1;
`endif
    end
  end

  // Head entry (ent0) drives the outputs; ent1 is the skid slot.
  issue_t     ent0, ent1;
  logic [1:0] cnt, cnt_nx;
  logic       rdy_q, push, pop;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid & out_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign push      = in_valid & in_ready;
`else
  assign push      = in_valid & in_ready & dec_ok;
`endif
  assign cnt_nx    = cnt + {1'b0, push} - {1'b0, pop};

  generate
    if (BUF_DEPTH == 1) begin : g_d1
      assign in_ready = !out_valid | out_ready;
    end else begin : g_d2
      assign in_ready = rdy_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
      rdy_q <= 1'b1;
    end else begin
      cnt   <= cnt_nx;
      rdy_q <= (cnt_nx < 2'd2);
      if (pop && cnt == 2'd2)
        ent0 <= ent1;
      else if (push && (cnt == 2'd0 || pop))
        ent0 <= dec;
      if (push && cnt == 2'd1 && !pop)
        ent1 <= dec;
    end
  end

  assign a       = ent0.a;
  assign b       = ent0.b;
  assign aluc    = ent0.aluc;
  assign wreg    = ent0.wreg;
  assign wn      = ent0.wn;
  assign m2reg   = ent0.m2reg;
  assign wmem    = ent0.wmem;
  assign br_eq   = ent0.br_eq;
  assign br_ne   = ent0.br_ne;
  assign illegal = ent0.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage (BUF_DEPTH=2): decode vectors, backpressure, reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
  logic [31:0] a, b;
  logic [3:0]  aluc;
  logic        wreg, m2reg, wmem, br_eq, br_ne, illegal;
  logic [4:0]  wn;
  int          total = 0, bad = 0;
  logic [79:0] exp;
  logic [79:0] obs;

  always #5 clk = ~clk;

  alu_issue_stage #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .aluc(aluc), .wreg(wreg), .wn(wn), .m2reg(m2reg), .wmem(wmem),
    .br_eq(br_eq), .br_ne(br_ne), .illegal(illegal)
  );

  assign obs = {out_valid, a, b, aluc, wreg, wn, m2reg, wmem, br_eq, br_ne, illegal};

  function automatic logic [79:0] ev(input logic v, input logic [31:0] ea, input logic [31:0] eb,
                                     input logic [3:0] ec, input logic ew, input logic [4:0] en,
                                     input logic em, input logic ewm, input logic ebe,
                                     input logic ebn, input logic eil);
    return {v, ea, eb, ec, ew, en, em, ewm, ebe, ebn, eil};
  endfunction

  // Present one instruction for exactly one clock with out_ready=1; returns at the next negedge.
  task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    out_ready = 1'b1; in_valid = 1'b1; instr = i; rs_data = rs; rt_data = rt;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp = '0;
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_out: got %h want %h", obs, exp); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rtype;
    send(32'h00221820, 32'd5, 32'd7);
    exp = ev(1, 32'd5, 32'd7, 4'b0000, 1, 5'd3, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL add: got %h want %h", obs, exp); end
    send(32'h00221822, 32'd20, 32'd3);
    exp = ev(1, 32'd20, 32'd3, 4'b0100, 1, 5'd3, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL sub: got %h want %h", obs, exp); end
    send(32'h00011100, 32'h99, 32'h0000000F);
    exp = ev(1, 32'd4, 32'h0000000F, 4'b0011, 1, 5'd2, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL sll: got %h want %h", obs, exp); end
    send(32'h000117C3, 32'h99, 32'h80000000);
    exp = ev(1, 32'd31, 32'h80000000, 4'b1111, 1, 5'd2, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL sra: got %h want %h", obs, exp); end
  endtask

  task automatic test_itype;
    send(32'h2001FFFF, 32'd10, 32'd0);
    exp = ev(1, 32'd10, 32'hFFFFFFFF, 4'b0000, 1, 5'd1, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL addi: got %h want %h", obs, exp); end
    send(32'h3401FFFF, 32'd10, 32'd0);
    exp = ev(1, 32'd10, 32'h0000FFFF, 4'b0101, 1, 5'd1, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL ori: got %h want %h", obs, exp); end
    send(32'h30218000, 32'd3, 32'd0);
    exp = ev(1, 32'd3, 32'h00008000, 4'b0001, 1, 5'd1, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL andi: got %h want %h", obs, exp); end
    send(32'h3C011234, 32'd0, 32'd0);
    exp = ev(1, 32'd0, 32'h00001234, 4'b0110, 1, 5'd1, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL lui: got %h want %h", obs, exp); end
    send(32'h8C22FFFC, 32'h100, 32'd0);
    exp = ev(1, 32'h100, 32'hFFFFFFFC, 4'b0000, 1, 5'd2, 1, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL lw: got %h want %h", obs, exp); end
    send(32'hAC22FFFC, 32'h200, 32'd0);
    exp = ev(1, 32'h200, 32'hFFFFFFFC, 4'b0000, 0, 5'd2, 0, 1, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL sw: got %h want %h", obs, exp); end
  endtask

  task automatic test_branch;
    send(32'h10220003, 32'd8, 32'd9);
    exp = ev(1, 32'd8, 32'd9, 4'b0010, 0, 5'd2, 0, 0, 1, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL beq: got %h want %h", obs, exp); end
    send(32'h14220003, 32'd8, 32'd8);
    exp = ev(1, 32'd8, 32'd8, 4'b0010, 0, 5'd2, 0, 0, 0, 1, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL bne: got %h want %h", obs, exp); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [79:0] e1, e2, e3;
    e1 = ev(1, 32'd1, 32'd2, 4'b0000, 1, 5'd3, 0, 0, 0, 0, 0);
    e2 = ev(1, 32'd10, 32'd3, 4'b0100, 1, 5'd3, 0, 0, 0, 0, 0);
    e3 = ev(1, 32'h0F, 32'hF0, 4'b0101, 1, 5'd3, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00221820; rs_data = 32'd1; rt_data = 32'd2;
    @(negedge clk);
    total++; if (obs !== e1) begin bad++; $display("FAIL bp_first: got %h want %h", obs, e1); end
    instr = 32'h00221822; rs_data = 32'd10; rt_data = 32'd3;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: in_ready=%b want 0", in_ready); end
    instr = 32'h00221825; rs_data = 32'h0F; rt_data = 32'hF0;
    @(negedge clk);
    total++; if (obs !== e1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL bp_hold: got %h rdy=%b want %h rdy=0", obs, in_ready, e1); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (obs !== e2 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_pop1: got %h rdy=%b want %h rdy=1", obs, in_ready, e2); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (obs !== e3) begin bad++; $display("FAIL bp_pop2: got %h want %h", obs, e3); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'h00221820; rs_data = 32'd100; rt_data = 32'd1;
    @(negedge clk);
    exp = ev(1, 32'd100, 32'd1, 4'b0000, 1, 5'd3, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL b2b_0: got %h want %h", obs, exp); end
    instr = 32'h38430055; rs_data = 32'hAA; rt_data = 32'd0;
    @(negedge clk);
    exp = ev(1, 32'hAA, 32'h55, 4'b0010, 1, 5'd3, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL b2b_xori: got %h want %h", obs, exp); end
    instr = 32'h00011082; rs_data = 32'd0; rt_data = 32'h80;
    @(negedge clk);
    in_valid = 1'b0;
    exp = ev(1, 32'd2, 32'h80, 4'b0111, 1, 5'd2, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL b2b_srl: got %h want %h", obs, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h00221820; rs_data = 32'd1; rt_data = 32'd1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL rm_fill: vld=%b rdy=%b want 1/0", out_valid, in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rm_clear: vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stay: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_illegal;
    send(32'hFC000000, 32'd5, 32'd6);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    exp = ev(1, 32'd0, 32'd0, 4'b0000, 0, 5'd0, 0, 0, 0, 0, 1);
    total++; if (obs !== exp) begin bad++; $display("FAIL illegal_op: got %h want %h", obs, exp); end
`else
    total++; if (out_valid !== 1'b0 || illegal !== 1'b0)
      begin bad++; $display("FAIL illegal_op: vld=%b ill=%b want 0/0", out_valid, illegal); end
`endif
    send(32'h0022183F, 32'd5, 32'd6);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    total++; if (obs !== exp) begin bad++; $display("FAIL illegal_funct: got %h want %h", obs, exp); end
`else
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL illegal_funct: vld=%b want 0", out_valid); end
`endif
    send(32'h00221820, 32'd5, 32'd6);
    exp = ev(1, 32'd5, 32'd6, 4'b0000, 1, 5'd3, 0, 0, 0, 0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL after_illegal: got %h want %h", obs, exp); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_branch;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
